// File: rtl/booth_pkg.sv
// Shared constants for the booth multiplier arbiter: default sizing and FSM encodings.
package booth_pkg;

  localparam int unsigned DefaultNReq    = 4;
  localparam int unsigned DefaultWidth   = 8;
  localparam int unsigned DefaultTimeout = 64;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StWait  = 2'd1;
  localparam arb_state_t StResp  = 2'd2;
  localparam arb_state_t StDrain = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick
  import booth_pkg::*;
#(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] cand;

  // Walk candidates ptr, ptr+1, ... (mod N_REQ) and keep the first valid one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_i} + SW'(i);
      if (cand >= SW'(N_REQ)) begin
        cand = cand - SW'(N_REQ);
      end
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                = 1'b1;
        idx_o                = cand[IW-1:0];
        gnt_o[cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one sequential multiplier among N_REQ clients.
// One op in flight at a time; a timed-out op drains the multiplier before the next grant.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned N_REQ   = DefaultNReq,
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_m,
  input  logic [N_REQ*WIDTH-1:0] req_q,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_p,
  output logic                   rsp_err,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_m,
  output logic [WIDTH-1:0]       mul_q,
  input  logic [2*WIDTH-1:0]     mul_p,
  input  logic                   mul_done,
  input  logic                   mul_busy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      gnt_id_q, gnt_id_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   opm_q, opm_d;
  logic [WIDTH-1:0]   opq_q, opq_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Next-state logic for the FSM, operand/product registers and the WAIT counter.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    opm_d    = opm_q;
    opq_d    = opq_q;
    prod_d   = prod_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          opm_d    = req_m[32'(pick_idx) * WIDTH +: WIDTH];
          opq_d    = req_q[32'(pick_idx) * WIDTH +: WIDTH];
          start_d  = 1'b1;
          gnt_id_d = pick_idx;
          ptr_d    = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          cnt_d    = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        // cnt_q == 0 marks the first WAIT cycle, where a done left over from a
        // previous op must not be taken as this op's result. Done beats timeout.
        if ((cnt_q != '0) && mul_done) begin
          prod_d  = mul_p;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready[gnt_id_q]) begin
          state_d = err_q ? StDrain : StIdle;
        end
      end
      StDrain: begin
        // The aborted op may still be running; wait it out before a new start.
        if (!mul_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous clear; a reset mid-op drops the op silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      opm_q    <= '0;
      opq_q    <= '0;
      prod_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      opm_q    <= opm_d;
      opq_q    <= opq_d;
      prod_q   <= prod_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    req_ready = (state_q == StIdle) ? pick_gnt : '0;
    rsp_valid = (state_q == StResp) ? (N_REQ'(1) << gnt_id_q) : '0;
  end

  assign rsp_p     = prod_q;
  assign rsp_err   = err_q;
  assign mul_start = start_q;
  assign mul_m     = opm_q;
  assign mul_q     = opq_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier stub.
module tb_booth_mult_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_m, req_q;
  logic [2*W-1:0] rsp_p, mul_p;
  logic           rsp_err, mul_start, mul_done, mul_busy;
  logic [W-1:0]   mul_m, mul_q;

  logic           stub_busy, stub_done, stub_hang, hang_busy;
  logic [2*W-1:0] stub_p;
  logic [3:0]     stub_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .TIMEOUT (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_m     (req_m),
    .req_q     (req_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_m     (mul_m),
    .mul_q     (mul_q),
    .mul_p     (mul_p),
    .mul_done  (mul_done),
    .mul_busy  (mul_busy)
  );

  // Multiplier stub: done pulse LAT+1 cycles after the start pulse; silent when hung.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= '0;
      stub_p    <= '0;
    end else begin
      stub_done <= 1'b0;
      if (mul_start && !stub_hang) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 4'(LAT);
        stub_p    <= 16'(mul_m) * 16'(mul_q);
      end else if (stub_busy) begin
        if (stub_cnt == 4'd1) begin
          stub_done <= 1'b1;
          stub_busy <= 1'b0;
        end
        stub_cnt <= stub_cnt - 4'd1;
      end
    end
  end

  assign mul_p    = stub_p;
  assign mul_done = stub_done;
  assign mul_busy = stub_busy | hang_busy;

  task automatic set_op(input int k, input logic [W-1:0] m, input logic [W-1:0] q);
    req_m[k*W +: W] = m;
    req_q[k*W +: W] = q;
  endtask

  task automatic wait_rsp(input int k, input int limit, output bit ok, output int cyc);
    cyc = 0;
    while (rsp_valid[k] !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    ok = (rsp_valid[k] === 1'b1);
  endtask

  task automatic handshake(input int k);
    rsp_ready = 4'(1 << k);
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_m = '0; req_q = '0;
    stub_hang = 1'b0; hang_busy = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_q} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b p=%0d err=%b st=%b m=%0d q=%0d want all 0",
               req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; int cyc;
    set_op(0, 8'd10, 8'd20);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_ready got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (mul_start !== 1'b1 || mul_m !== 8'd10 || mul_q !== 8'd20) begin
      errors++;
      $display("FAIL single_start got st=%b m=%0d q=%0d want 1 10 20", mul_start, mul_m, mul_q);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0) begin
      errors++; $display("FAIL single_start_pulse got %b want 0", mul_start);
    end
    wait_rsp(0, 100, ok, cyc);
    checks++;
    if (!ok || cyc + 1 != 5) begin
      errors++; $display("FAIL single_latency got ok=%b lat=%0d want 5", ok, cyc + 1);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_p !== 16'd200 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got vld=%b p=%0d err=%b want 0001 200 0", rsp_valid, rsp_p, rsp_err);
    end
    handshake(0);
    checks++;
    if (rsp_valid !== 4'b0000 || mul_start !== 1'b0) begin
      errors++; $display("FAIL single_after got vld=%b st=%b want 0000 0", rsp_valid, mul_start);
    end
  endtask

  task automatic test_all_four();
    bit ok; int cyc;
    logic [15:0] exp_p [4];
    exp_p[0] = 16'd16129; exp_p[1] = 16'd1500; exp_p[2] = 16'd200; exp_p[3] = 16'd9;
    set_op(0, 8'd127, 8'd127);
    set_op(1, 8'd15, 8'd100);
    set_op(2, 8'd10, 8'd20);
    set_op(3, 8'd3, 8'd3);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (req_ready !== 4'(1 << k)) begin
        errors++; $display("FAIL all_grant%0d got %b want %b", k, req_ready, 4'(1 << k));
      end
      @(negedge clk);
      req_valid[k] = 1'b0;
      wait_rsp(k, 100, ok, cyc);
      checks++;
      if (!ok || rsp_p !== exp_p[k] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL all_prod%0d got ok=%b p=%0d err=%b want %0d", k, ok, rsp_p, rsp_err, exp_p[k]);
      end
      handshake(k);
    end
  endtask

  task automatic test_rerequest();
    bit ok; int cyc;
    set_op(1, 8'd5, 8'd6);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rereq_first got %b want 0010", req_ready);
    end
    @(negedge clk);
    set_op(2, 8'd7, 8'd8);
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL rereq_wait_ready got %b want 0000", req_ready);
    end
    wait_rsp(1, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd30 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL rereq_rsp1 got ok=%b p=%0d rdy=%b want 30 0000", ok, rsp_p, req_ready);
    end
    handshake(1);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL rereq_second got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    wait_rsp(2, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd56) begin
      errors++; $display("FAIL rereq_rsp2 got ok=%b p=%0d want 56", ok, rsp_p);
    end
    handshake(2);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL rereq_third got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd30) begin
      errors++; $display("FAIL rereq_rsp3 got ok=%b p=%0d want 30", ok, rsp_p);
    end
    handshake(1);
  endtask

  task automatic test_hold();
    bit ok; int cyc;
    set_op(3, 8'd9, 8'd11);
    set_op(0, 8'd2, 8'd2);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL hold_grant got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(3, 100, ok, cyc);
    req_valid = 4'b0001;
    rsp_ready = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (!ok || rsp_valid !== 4'b1000 || rsp_p !== 16'd99 || rsp_err !== 1'b0 ||
          req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%b p=%0d err=%b rdy=%b want 1000 99 0 0000",
                 i, rsp_valid, rsp_p, rsp_err, req_ready);
      end
      @(negedge clk);
    end
    handshake(3);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL hold_next_grant got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(0, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd4) begin
      errors++; $display("FAIL hold_rsp0 got ok=%b p=%0d want 4", ok, rsp_p);
    end
    handshake(0);
  endtask

  task automatic test_timeout();
    bit ok; int cyc;
    bit drain_bad;
    stub_hang = 1'b1;
    hang_busy = 1'b1;
    set_op(1, 8'd3, 8'd3);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL tmo_grant got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(1, 200, ok, cyc);
    checks++;
    if (!ok || cyc != 64) begin
      errors++; $display("FAIL tmo_cycles got ok=%b cyc=%0d want 64", ok, cyc);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_p !== 16'd0 || rsp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL tmo_rsp got err=%b p=%0d vld=%b want 1 0 0010", rsp_err, rsp_p, rsp_valid);
    end
    handshake(1);
    set_op(2, 8'd4, 8'd5);
    req_valid = 4'b0100;
    drain_bad = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) drain_bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (drain_bad) begin
      errors++; $display("FAIL tmo_drain got a grant or response while busy want none");
    end
    stub_hang = 1'b0;
    hang_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL tmo_after_drain got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(2, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd20 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL tmo_recover got ok=%b p=%0d err=%b want 20 0", ok, rsp_p, rsp_err);
    end
    handshake(2);
  endtask

  task automatic test_reset_mid();
    bit ok; int cyc;
    bit seen;
    set_op(2, 8'd6, 8'd7);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL rmid_grant got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_q} !== '0) begin
      errors++;
      $display("FAIL rmid_clear got rdy=%b vld=%b p=%0d err=%b st=%b m=%0d q=%0d want all 0",
               req_ready, rsp_valid, rsp_p, rsp_err, mul_start, mul_m, mul_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL rmid_no_rsp got a response after reset want none");
    end
    set_op(0, 8'd12, 8'd12);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_ptr got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    wait_rsp(0, 100, ok, cyc);
    checks++;
    if (!ok || rsp_p !== 16'd144) begin
      errors++; $display("FAIL rmid_rsp got ok=%b p=%0d want 144", ok, rsp_p);
    end
    handshake(0);
  endtask

  initial begin
    test_reset();
    test_single();
    apply_reset();
    test_all_four();
    test_rerequest();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
